// File: rtl/defines_pkg.sv
// Shared definitions for the interrupt-to-trap arbiter: register map and FSM states.
package defines_pkg;

    localparam logic [1:0] ADDR_ENABLE  = 2'd0;
    localparam logic [1:0] ADDR_PENDING = 2'd1;
    localparam logic [1:0] ADDR_MODE    = 2'd2;
    localparam logic [1:0] ADDR_LAST_ID = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

endpackage

// File: rtl/ex_irq_arb_if.sv
// Configuration bus and core trap handshake of the interrupt arbiter.
interface ex_irq_arb_if #(
    parameter int unsigned NSRC = 8
);
    localparam int unsigned IDW = $clog2(NSRC);

    logic            cfg_we;
    logic [1:0]      cfg_addr;
    logic [31:0]     cfg_wdata;
    logic [31:0]     cfg_rdata;
    logic            core_ex_trap_valid;
    logic            core_ex_trap_ready;
    logic [IDW-1:0]  trap_id_o;

    modport master (
        output cfg_we, cfg_addr, cfg_wdata, core_ex_trap_ready,
        input  cfg_rdata, core_ex_trap_valid, trap_id_o
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_wdata, core_ex_trap_ready,
        output cfg_rdata, core_ex_trap_valid, trap_id_o
    );

endinterface

// File: rtl/irq_prio_sel.sv
// Rotating find-first selector: first set candidate at or after start_i, wrapping modulo NSRC.
module irq_prio_sel #(
    parameter int unsigned NSRC = 8,
    parameter int unsigned IDW  = 3
) (
    input  logic [NSRC-1:0] cand_i,
    input  logic [IDW-1:0]  start_i,
    output logic            found_c,
    output logic [IDW-1:0]  idx_c
);

    int unsigned pos;

    always_comb begin
        found_c = 1'b0;
        idx_c   = '0;
        pos     = 0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            pos = (32'(start_i) + k) % NSRC;
            if (!found_c && cand_i[IDW'(pos)]) begin
                found_c = 1'b1;
                idx_c   = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/ex_irq_arb.sv
// Interrupt arbiter: edge-detected pending sources, enable/mode registers, one trap
// request at a time towards the core with a fixed idle gap after every acceptance.
module ex_irq_arb
    import defines_pkg::*;
#(
    parameter int unsigned NSRC = 8,
    parameter int unsigned GAP  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NSRC-1:0] src_i,
    output logic            busy_o,
    ex_irq_arb_if.slave     bus
);

    localparam int unsigned    IDW    = $clog2(NSRC);
    localparam int unsigned    GW     = 4;
    localparam logic [IDW-1:0] ID_MAX = IDW'(NSRC - 1);

    state_e          state_q, state_d;
    logic [GW-1:0]   gap_cnt_q, gap_cnt_d;
    logic [NSRC-1:0] src_q, pend_q, pend_d, en_q, en_d;
    logic            mode_q, mode_d;
    logic [IDW-1:0]  last_id_q, last_id_d, trap_id_q, trap_id_d;
    logic            valid_q, valid_d, busy_q, busy_d;

    logic [NSRC-1:0] rise_c, cand_c, clr_c;
    logic [IDW-1:0]  start_c, sel_idx_c;
    logic            sel_found_c, ack_c;
    logic            unused_wdata;

    assign rise_c  = src_i & ~src_q;
    assign cand_c  = pend_q & en_q;
    assign ack_c   = (state_q == ST_REQ) && bus.core_ex_trap_ready;
    // Round-robin starts just after the last served source so it gets lowest priority.
    assign start_c = !mode_q              ? '0 :
                     (last_id_q == ID_MAX) ? '0 : IDW'(last_id_q + 1'b1);

    irq_prio_sel #(
        .NSRC (NSRC),
        .IDW  (IDW)
    ) u_sel (
        .cand_i  (cand_c),
        .start_i (start_c),
        .found_c (sel_found_c),
        .idx_c   (sel_idx_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        unique case (state_q)
            ST_IDLE: if (sel_found_c) state_d = ST_REQ;
            ST_REQ: begin
                if (ack_c) begin
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_GAP;
                        gap_cnt_d = GW'(GAP - 1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == '0) state_d = ST_IDLE;
                else                 gap_cnt_d = gap_cnt_q - 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A rising edge in the same cycle overrides any clear (W1C or acceptance).
    always_comb begin
        clr_c = '0;
        if (bus.cfg_we && bus.cfg_addr == ADDR_PENDING) clr_c = bus.cfg_wdata[NSRC-1:0];
        if (ack_c) clr_c[trap_id_q] = 1'b1;
        pend_d    = (pend_q & ~clr_c) | rise_c;
        en_d      = (bus.cfg_we && bus.cfg_addr == ADDR_ENABLE) ? bus.cfg_wdata[NSRC-1:0] : en_q;
        mode_d    = (bus.cfg_we && bus.cfg_addr == ADDR_MODE)   ? bus.cfg_wdata[0]         : mode_q;
        last_id_d = ack_c ? trap_id_q : last_id_q;
        trap_id_d = (state_q == ST_IDLE && sel_found_c) ? sel_idx_c : trap_id_q;
        valid_d   = (state_d == ST_REQ);
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            src_q     <= '0;
            pend_q    <= '0;
            en_q      <= '0;
            mode_q    <= 1'b0;
            last_id_q <= '0;
            trap_id_q <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            src_q     <= src_i;
            pend_q    <= pend_d;
            en_q      <= en_d;
            mode_q    <= mode_d;
            last_id_q <= last_id_d;
            trap_id_q <= trap_id_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        bus.cfg_rdata = '0;
        unique case (bus.cfg_addr)
            ADDR_ENABLE:  bus.cfg_rdata = 32'(en_q);
            ADDR_PENDING: bus.cfg_rdata = 32'(pend_q);
            ADDR_MODE:    bus.cfg_rdata = 32'(mode_q);
            ADDR_LAST_ID: bus.cfg_rdata = 32'(last_id_q);
        endcase
    end

    assign bus.core_ex_trap_valid = valid_q;
    assign bus.trap_id_o          = trap_id_q;
    assign busy_o                 = busy_q;
    assign unused_wdata           = ^bus.cfg_wdata;

endmodule

// File: tb/tb_ex_irq_arb.sv
// Self-checking bench for ex_irq_arb: directed scenarios plus randomized traffic
// compared against a behavioural reference model.
module tb_ex_irq_arb;
    import defines_pkg::*;

    localparam int unsigned NSRC = 8;
    localparam int unsigned GAP  = 2;
    localparam int unsigned IDW  = $clog2(NSRC);

    logic            clk = 1'b0;
    logic            rst;
    logic [NSRC-1:0] src_i;
    logic            busy_o;

    ex_irq_arb_if #(.NSRC(NSRC)) bus ();

    ex_irq_arb #(.NSRC(NSRC), .GAP(GAP)) dut (
        .clk    (clk),
        .rst    (rst),
        .src_i  (src_i),
        .busy_o (busy_o),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    bit m_pend[NSRC];
    bit m_en[NSRC];
    bit m_src[NSRC];
    bit m_mode;
    bit m_req;
    int m_id;
    int m_last;
    int m_gap;

    function automatic int pick();
        int start = m_mode ? (m_last + 1) % NSRC : 0;
        for (int k = 0; k < NSRC; k++) begin
            int j = (start + k) % NSRC;
            if (m_pend[j] && m_en[j]) return j;
        end
        return -1;
    endfunction

    function automatic bit m_busy();
        return m_req || (m_gap > 0);
    endfunction

    function automatic logic [31:0] m_rdata(logic [1:0] a);
        logic [31:0] r = '0;
        case (a)
            ADDR_ENABLE:  for (int i = 0; i < NSRC; i++) r[i] = m_en[i];
            ADDR_PENDING: for (int i = 0; i < NSRC; i++) r[i] = m_pend[i];
            ADDR_MODE:    r[0] = m_mode;
            default:      r = 32'(m_last);
        endcase
        return r;
    endfunction

    task automatic model_edge();
        int w;
        bit ack;
        if (rst) begin
            for (int i = 0; i < NSRC; i++) begin
                m_pend[i] = 0; m_en[i] = 0; m_src[i] = 0;
            end
            m_mode = 0; m_req = 0; m_id = 0; m_last = 0; m_gap = 0;
            return;
        end
        ack = m_req && bus.core_ex_trap_ready;
        w   = (!m_req && m_gap == 0) ? pick() : -1;
        for (int i = 0; i < NSRC; i++) begin
            bit e = src_i[i] && !m_src[i];
            bit c = (bus.cfg_we && bus.cfg_addr == ADDR_PENDING && bus.cfg_wdata[i]) || (ack && m_id == i);
            m_pend[i] = e || (m_pend[i] && !c);
            m_src[i]  = src_i[i];
            if (bus.cfg_we && bus.cfg_addr == ADDR_ENABLE) m_en[i] = bus.cfg_wdata[i];
        end
        if (bus.cfg_we && bus.cfg_addr == ADDR_MODE) m_mode = bus.cfg_wdata[0];
        if (ack) begin
            m_last = m_id;
            m_req  = 0;
            m_gap  = GAP;
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (w >= 0) begin
            m_req = 1;
            m_id  = w;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        src_i = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.core_ex_trap_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic cfg_write(logic [1:0] a, logic [31:0] d);
        bus.cfg_we = 1'b1; bus.cfg_addr = a; bus.cfg_wdata = d;
        tick();
        bus.cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        n_tests++;
        if (bus.core_ex_trap_valid !== 1'b0 || bus.trap_id_o !== '0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out: valid=%b id=%0d busy=%b, want 0 0 0", bus.core_ex_trap_valid, bus.trap_id_o, busy_o);
        end
        for (int a = 0; a < 4; a++) begin
            bus.cfg_addr = 2'(a);
            #1;
            n_tests++;
            if (bus.cfg_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_reg%0d: got %h want 0", a, bus.cfg_rdata);
            end
        end
    endtask

    task automatic test_fixed_prio();
        int grants[$];
        int when[$];
        int spacing;
        do_reset();
        cfg_write(ADDR_ENABLE, 32'hFF);
        bus.core_ex_trap_ready = 1'b1;
        src_i = 8'h24; tick(); src_i = '0;
        for (int c = 0; c < 30; c++) begin
            tick();
            n_tests++;
            if (bus.core_ex_trap_valid !== m_req || bus.trap_id_o !== IDW'(m_id) || busy_o !== m_busy()) begin
                n_fail++;
                $display("FAIL fixed_model c%0d: valid=%b id=%0d busy=%b, want %b %0d %b",
                         c, bus.core_ex_trap_valid, bus.trap_id_o, busy_o, m_req, m_id, m_busy());
            end
            if (bus.core_ex_trap_valid) begin
                grants.push_back(int'(bus.trap_id_o));
                when.push_back(c);
            end
        end
        bus.core_ex_trap_ready = 1'b0;
        n_tests++;
        if (grants.size() != 2 || grants[0] != 2 || grants[1] != 5) begin
            n_fail++;
            $display("FAIL fixed_order: got %p want '{2,5}", grants);
        end
        spacing = (when.size() >= 2) ? when[1] - when[0] : -1;
        n_tests++;
        if (spacing != GAP + 2) begin
            n_fail++;
            $display("FAIL fixed_gap: valid-to-valid %0d cycles, want %0d", spacing, GAP + 2);
        end
    endtask

    task automatic test_round_robin();
        int grants[$];
        int exp_order[6] = '{0, 1, 3, 0, 1, 3};
        int last_g = -1;
        bit got = 0;
        bit bad = 0;
        logic [NSRC-1:0] next_src = '0;
        do_reset();
        cfg_write(ADDR_ENABLE, 32'h8B);
        bus.core_ex_trap_ready = 1'b1;
        // Serve source 7 first so round-robin starts searching from index 0.
        src_i = 8'h80; tick(); src_i = '0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            got = bus.core_ex_trap_valid;
        end
        for (int c = 0; c < 6; c++) tick();
        cfg_write(ADDR_MODE, 32'h1);
        n_tests++;
        bus.cfg_addr = ADDR_LAST_ID;
        #1;
        if (!got || bus.cfg_rdata !== 32'd7) begin
            n_fail++;
            $display("FAIL rr_prime: got valid=%b last_id=%0d want 1 7", got, bus.cfg_rdata);
        end
        src_i = 8'h0B; tick(); src_i = '0;
        for (int c = 0; c < 120 && grants.size() < 6; c++) begin
            src_i = next_src;
            next_src = '0;
            bus.cfg_addr = ADDR_LAST_ID;
            tick();
            n_tests++;
            if (bus.core_ex_trap_valid !== m_req || bus.trap_id_o !== IDW'(m_id) || bus.cfg_rdata !== m_rdata(ADDR_LAST_ID)) begin
                n_fail++;
                $display("FAIL rr_model c%0d: valid=%b id=%0d last=%0d, want %b %0d %0d",
                         c, bus.core_ex_trap_valid, bus.trap_id_o, bus.cfg_rdata, m_req, m_id, m_last);
            end
            if (last_g >= 0) begin
                n_tests++;
                if (bus.cfg_rdata !== 32'(last_g)) begin
                    n_fail++;
                    $display("FAIL rr_last_id: got %0d want %0d", bus.cfg_rdata, last_g);
                end
            end
            last_g = -1;
            if (bus.core_ex_trap_valid) begin
                grants.push_back(int'(bus.trap_id_o));
                last_g = int'(bus.trap_id_o);
                next_src = {{(NSRC-1){1'b0}}, 1'b1} << bus.trap_id_o;
            end
        end
        src_i = '0;
        bus.core_ex_trap_ready = 1'b0;
        if (grants.size() != 6) bad = 1;
        for (int i = 0; i < 6 && i < grants.size(); i++) if (grants[i] != exp_order[i]) bad = 1;
        n_tests++;
        if (bad) begin
            n_fail++;
            $display("FAIL rr_order: got %p want '{0,1,3,0,1,3}", grants);
        end
    endtask

    task automatic test_hold_no_retract();
        bit got = 0;
        do_reset();
        cfg_write(ADDR_ENABLE, 32'hFF);
        src_i = 8'h10; tick(); src_i = '0;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            got = bus.core_ex_trap_valid;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL hold_timeout: valid=%b want 1 within 10 cycles", bus.core_ex_trap_valid);
        end
        for (int c = 0; c < 20; c++) begin
            bus.cfg_we = (c == 5); bus.cfg_addr = ADDR_ENABLE; bus.cfg_wdata = 32'hEF;
            tick();
            bus.cfg_we = 1'b0;
            n_tests++;
            if (bus.core_ex_trap_valid !== 1'b1 || bus.trap_id_o !== IDW'(4)) begin
                n_fail++;
                $display("FAIL hold c%0d: valid=%b id=%0d want 1 4", c, bus.core_ex_trap_valid, bus.trap_id_o);
            end
        end
        bus.core_ex_trap_ready = 1'b1; tick(); bus.core_ex_trap_ready = 1'b0;
        n_tests++;
        if (bus.core_ex_trap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: valid=%b want 0", bus.core_ex_trap_valid);
        end
        bus.cfg_addr = ADDR_PENDING;
        #1;
        n_tests++;
        if (bus.cfg_rdata[4] !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_pend4: got %b want 0", bus.cfg_rdata[4]);
        end
    endtask

    task automatic test_w1c_vs_edge();
        do_reset();
        src_i = 8'h40;
        bus.cfg_we = 1'b1; bus.cfg_addr = ADDR_PENDING; bus.cfg_wdata = 32'h40;
        tick();
        bus.cfg_we = 1'b0;
        n_tests++;
        if (bus.cfg_rdata !== 32'h40) begin
            n_fail++;
            $display("FAIL w1c_edge_wins: pending=%h want 00000040", bus.cfg_rdata);
        end
        cfg_write(ADDR_PENDING, 32'hFFFF_FFFF);
        n_tests++;
        if (bus.cfg_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL w1c_clear: pending=%h want 0", bus.cfg_rdata);
        end
        src_i = '0;
    endtask

    task automatic test_reset_in_req();
        bit got = 0;
        do_reset();
        cfg_write(ADDR_ENABLE, 32'hFF);
        cfg_write(ADDR_MODE, 32'h1);
        src_i = 8'h08;
        for (int c = 0; c < 10 && !got; c++) begin
            tick();
            got = bus.core_ex_trap_valid;
        end
        n_tests++;
        if (!got || bus.trap_id_o !== IDW'(3)) begin
            n_fail++;
            $display("FAIL rstreq_setup: valid=%b id=%0d want 1 3", got, bus.trap_id_o);
        end
        rst = 1'b1;
        tick();
        n_tests++;
        if (bus.core_ex_trap_valid !== 1'b0 || busy_o !== 1'b0 || bus.trap_id_o !== '0) begin
            n_fail++;
            $display("FAIL rstreq_out: valid=%b busy=%b id=%0d want 0 0 0", bus.core_ex_trap_valid, busy_o, bus.trap_id_o);
        end
        for (int a = 0; a < 4; a++) begin
            bus.cfg_addr = 2'(a);
            #1;
            n_tests++;
            if (bus.cfg_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL rstreq_reg%0d: got %h want 0", a, bus.cfg_rdata);
            end
        end
        rst = 1'b0;
        tick();
        bus.cfg_addr = ADDR_PENDING;
        #1;
        n_tests++;
        if (bus.cfg_rdata !== 32'h08) begin
            n_fail++;
            $display("FAIL rst_release_edge: pending=%h want 00000008", bus.cfg_rdata);
        end
        src_i = '0;
    endtask

    task automatic test_enable_late();
        do_reset();
        cfg_write(ADDR_ENABLE, 32'h7F);
        src_i = 8'h80; tick(); src_i = '0;
        for (int c = 0; c < 5; c++) begin
            tick();
            n_tests++;
            if (bus.core_ex_trap_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL masked c%0d: valid=%b want 0", c, bus.core_ex_trap_valid);
            end
        end
        cfg_write(ADDR_ENABLE, 32'hFF);
        n_tests++;
        if (bus.core_ex_trap_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_same_cycle: valid=%b want 0", bus.core_ex_trap_valid);
        end
        tick();
        n_tests++;
        if (bus.core_ex_trap_valid !== 1'b1 || bus.trap_id_o !== IDW'(7)) begin
            n_fail++;
            $display("FAIL enable_late: valid=%b id=%0d want 1 7", bus.core_ex_trap_valid, bus.trap_id_o);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.cfg_we = ($urandom_range(0, 4) == 0);
            bus.cfg_addr = 2'($urandom_range(0, 3));
            bus.cfg_wdata = $urandom();
            bus.core_ex_trap_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 2) == 0) src_i = NSRC'($urandom()) & NSRC'($urandom());
            tick();
            n_tests++;
            if (bus.core_ex_trap_valid !== m_req || bus.trap_id_o !== IDW'(m_id) ||
                busy_o !== m_busy() || bus.cfg_rdata !== m_rdata(bus.cfg_addr)) begin
                n_fail++;
                $display("FAIL random c%0d: valid=%b id=%0d busy=%b rd[%0d]=%h, want %b %0d %b %h",
                         c, bus.core_ex_trap_valid, bus.trap_id_o, busy_o, bus.cfg_addr, bus.cfg_rdata,
                         m_req, m_id, m_busy(), m_rdata(bus.cfg_addr));
            end
        end
        rst = 1'b0;
        bus.cfg_we = 1'b0;
        src_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        src_i = '0;
        bus.cfg_we = 1'b0; bus.cfg_addr = '0; bus.cfg_wdata = '0;
        bus.core_ex_trap_ready = 1'b0;
        test_reset();
        test_fixed_prio();
        test_round_robin();
        test_hold_no_retract();
        test_w1c_vs_edge();
        test_reset_in_req();
        test_enable_late();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ex_irq_arb.md
EX_IRQ_ARB -- requirements
Module: ex_irq_arb

Interface
REQ-001 SHALL have parameter NSRC, default 8, giving the number of interrupt sources (2..32).
REQ-002 SHALL have parameter GAP, default 2, giving the idle cycles forced after each acknowledged trap (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port src_i  input  NSRC  interrupt sources, synchronous to clk.
REQ-006 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-007 SHALL have port cfg_addr  input  2  register select: 0 ENABLE, 1 PENDING, 2 MODE, 3 LAST_ID.
REQ-008 SHALL have port cfg_wdata  input  32  write data.
REQ-009 SHALL have port cfg_rdata  output  32  combinational read of the register at cfg_addr; unused bits are 0.
REQ-010 SHALL have port core_ex_trap_valid  output  1  trap request to the core.
REQ-011 SHALL have port core_ex_trap_ready  input  1  core acceptance of the trap.
REQ-012 SHALL have port trap_id_o  output  clog2(NSRC)  index of the source being requested.
REQ-013 SHALL have port busy_o  output  1  high whenever the state is not IDLE.

Function
REQ-014 SHALL set pending[i] when src_i[i] is 1 in the current cycle and was 0 in the previous registered sample (rising edge).
REQ-015 SHALL clear pending[i] on a cfg write to PENDING with wdata[i]=1 (write-1-to-clear); a same-cycle rising edge on src_i[i] SHALL win, leaving pending[i]=1.
REQ-016 SHALL treat ENABLE and MODE as read/write; MODE bit0=1 selects round-robin, 0 selects fixed priority (index 0 highest); LAST_ID SHALL be read-only.
REQ-017 SHALL form the candidate set as pending & ENABLE.
REQ-018 SHALL implement the states IDLE, REQ and GAP.
REQ-019 SHALL, in IDLE with a non-empty candidate set, latch the winner into trap_id_o and enter REQ; core_ex_trap_valid SHALL rise on the following cycle (1-cycle latency from pending).
REQ-020 SHALL hold core_ex_trap_valid=1 and trap_id_o stable in REQ until core_ex_trap_ready=1, even if the ENABLE bit or pending bit of the latched source is cleared meanwhile (no retraction).
REQ-021 SHALL, on a cycle in REQ with core_ex_trap_ready=1, clear pending[trap_id_o] (unless a new edge arrives in that cycle), update LAST_ID, deassert valid on the next cycle, and enter GAP, or enter IDLE directly when GAP=0.
REQ-022 SHALL remain in GAP for exactly GAP cycles and then return to IDLE; no new selection SHALL be made in GAP.
REQ-023 SHALL, in round-robin mode, search from index LAST_ID+1 upward, wrapping modulo NSRC, so that the source just served has lowest priority.
REQ-024 SHALL ignore core_ex_trap_ready outside REQ.
REQ-025 SHALL ignore writes to bits at or above NSRC in ENABLE and PENDING.

Reset
REQ-026 SHALL, on rst=1, clear pending, ENABLE, MODE, LAST_ID and the src_i sample register, and enter IDLE with core_ex_trap_valid=0, trap_id_o=0 and busy_o=0.
REQ-027 SHALL abort an outstanding REQ on rst without waiting for ready; a src_i held high across reset release SHALL register as an edge in the first cycle after release.

Structure
REQ-028 SHALL place the register address constants and the state enum (IDLE/REQ/GAP) in the shared package defines_pkg.
REQ-029 SHALL contain exactly one sub-module, irq_prio_sel: a combinational rotate-and-find-first selector (inputs candidate vector and start index; outputs found and index).

Verification
REQ-030 SHALL cover: ENABLE=0xFF, fixed priority, src_i[5] and src_i[2] pulse in the same cycle -> trap_id_o=2 served first, then 5 after GAP=2 idle cycles.
REQ-031 SHALL cover: round-robin, sources 0,1,3 held pending and re-pulsed after each service -> grant order 0,1,3,0,1,3; LAST_ID tracks each grant.
REQ-032 SHALL cover: ready held 0 for 20 cycles, with ENABLE[4] cleared mid-REQ -> valid stays 1 and trap_id_o stays 4 until ready, then pending[4]=0.
REQ-033 SHALL cover: a W1C write to PENDING bit 6 in the same cycle as a src_i[6] rising edge -> pending[6] reads 1.
REQ-034 SHALL cover: rst asserted while in REQ -> valid=0 on the next cycle and all registers read 0.
REQ-035 SHALL cover: source 7 pending with ENABLE=0x7F -> no trap; writing ENABLE=0xFF -> valid asserted 1 cycle later with trap_id_o=7.
